dcache_controller: RTL and testbench

- MEM-stage data cache sitting between the EX/MEM pipeline register and data memory; its read data and stall output feed the MEM/WB register (mem_i, MEM_WB_stall_i) and the upstream pipeline registers.
- Direct-mapped, write-back, write-allocate cache of 32 lines × 256-bit blocks.
- Word hits complete in the same cycle; misses stall the pipeline while an FSM performs an optional dirty-victim writeback and then a block refill over an enable/ack memory handshake.

---
 rtl/dcache_controller.sv | 140 ++++++++++++++
 tb/tb_dcache_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Word hits complete combinationally; misses stall while the FSM writes back
// a dirty victim (if any) and refills the block over an enable/ack handshake.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   S_IDLE       | serving hits; a missing request moves to S_MISS
//   S_MISS       | one cycle to decide between writeback and refill
//   S_WRITEBACK  | dirty victim block written to memory, held until ack
//   S_ALLOCATE   | block read from memory, held until ack; line filled on ack
//   S_ALLOC_DONE | one settle cycle before the access replays as a hit
module dcache_controller #(
  parameter int LINES   = 32,
  parameter int BLOCK_W = 256,
  parameter int ADDR_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [31:0]        wdata_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  output logic [31:0]        rdata_o,
  output logic               stall_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_wdata_o,
  input  logic [BLOCK_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i
);

  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(BLOCK_W / 8);
  localparam int WSEL_W = OFF_W - 2;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_ALLOCATE,
    S_ALLOC_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  index;
  logic [WSEL_W-1:0] word;
  logic              req, hit, write_hit, read_hit, refill;
  logic              unused_addr_bits;

  assign tag   = addr_i[ADDR_W-1 -: TAG_W];
  assign index = addr_i[OFF_W +: IDX_W];
  assign word  = addr_i[2 +: WSEL_W];
  // byte lanes are not supported; accesses are whole words
  assign unused_addr_bits = ^addr_i[1:0];

  assign req       = MemRead_i | MemWrite_i;
  assign hit       = valid_q[index] & (tag_q[index] == tag);
  // a simultaneous read and write request is treated as a store
  assign write_hit = (state_q == S_IDLE) & MemWrite_i & hit;
  assign read_hit  = (state_q == S_IDLE) & MemRead_i & ~MemWrite_i & hit;
  assign refill    = (state_q == S_ALLOCATE) & mem_ack_i;

  assign stall_o = (state_q != S_IDLE) | (req & ~hit);
  assign rdata_o = read_hit ? data_q[index][{word, 5'd0} +: 32] : 32'd0;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // line status: refill makes a line valid and clean, a store hit dirties it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // tag and data arrays; contents are meaningless until the valid bit is set
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[index] <= mem_rdata_i;
      tag_q[index]  <= tag;
    end else if (write_hit) begin
      data_q[index][{word, 5'd0} +: 32] <= wdata_i;
    end
  end

  // next state and memory-side request outputs
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (req & ~hit) state_d = S_MISS;
      end
      S_MISS: begin
        if (valid_q[index] & dirty_q[index]) state_d = S_WRITEBACK;
        else                                 state_d = S_ALLOCATE;
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[index], index, {OFF_W{1'b0}}};
        mem_wdata_o  = data_q[index];
        if (mem_ack_i) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, index, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_ALLOC_DONE;
      end
      S_ALLOC_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller. A word-level golden memory holds the value
// every address must read as; a block-level memory model answers the cache.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic         MemRead_i = 1'b0;
  logic         MemWrite_i = 1'b0;
  logic [31:0]  rdata_o;
  logic         stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i = '0;
  logic         mem_ack_i;
  logic         resp_ack = 1'b0;
  logic         spur_ack = 1'b0;

  assign mem_ack_i = resp_ack | spur_ack;

  dcache_controller dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .MemRead_i    (MemRead_i),
    .MemWrite_i   (MemWrite_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  int resp_delay = 1;
  int resp_cnt = 0;
  int n_rd = 0;
  int n_wr = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;

  // gold: what each word must read as; mem_w: what memory itself holds
  logic [31:0] gold  [logic [29:0]];
  logic [31:0] mem_w [logic [29:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    if (wa == 30'h12) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ {2'b00, wa};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a[31:2])) return gold[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem_w.exists(wa)) return mem_w[wa];
    return init_word(wa);
  endfunction

  // memory responder: ack on the resp_delay-th cycle of a request
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      resp_ack = 1'b0;
      resp_cnt = 0;
    end else begin
      if (resp_ack) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end
      if (mem_enable_o) begin
        resp_cnt++;
        if (resp_cnt >= resp_delay) begin
          resp_ack = 1'b1;
          if (mem_write_o) begin
            n_wr++;
            last_wb_addr = mem_addr_o;
            last_wb_data = mem_wdata_o;
            for (int i = 0; i < 8; i++) begin
              logic [29:0] wa;
              wa = mem_addr_o[31:2] + 30'(i);
              mem_w[wa] = mem_wdata_o[i*32 +: 32];
            end
          end else begin
            n_rd++;
            last_rd_addr = mem_addr_o;
            for (int i = 0; i < 8; i++) begin
              logic [29:0] wa;
              wa = mem_addr_o[31:2] + 30'(i);
              mem_rdata_i[i*32 +: 32] = mem_rd(wa);
            end
          end
        end
      end
    end
  end

  // per-cycle checker against the golden memory and the handshake rules
  logic        ack_edge = 1'b0;
  logic        prev_en = 1'b0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk_i) ack_edge <= mem_ack_i;

  initial forever begin
    @(negedge clk_i);
    #1;
    if (rst_i) begin
      prev_en = 1'b0;
    end else begin
      if (!MemRead_i && !MemWrite_i) begin
        chk("idle_stall", 32'(stall_o), 32'd0);
        chk("idle_mem_en", 32'(mem_enable_o), 32'd0);
        chk("idle_rdata", rdata_o, 32'd0);
      end
      if (MemRead_i && !MemWrite_i && !stall_o)
        chk("load_data", rdata_o, gold_rd(addr_i));
      if (MemRead_i && stall_o)
        chk("stall_rdata", rdata_o, 32'd0);
      if (mem_enable_o)
        chk("blk_align", {27'd0, mem_addr_o[4:0]}, 32'd0);
      if (mem_enable_o && mem_write_o) begin
        int j;
        j = 0;
        for (int i = 7; i >= 0; i--)
          if (mem_wdata_o[i*32 +: 32] !== gold_rd(mem_addr_o + 32'(i*4))) j = i;
        chk("wb_word", mem_wdata_o[j*32 +: 32], gold_rd(mem_addr_o + 32'(j*4)));
      end
      if (prev_en && !ack_edge) begin
        chk("hold_en", 32'(mem_enable_o), 32'd1);
        chk("hold_addr", mem_addr_o, prev_addr);
        chk("hold_wr", 32'(mem_write_o), 32'(prev_wr));
      end
      prev_en   = mem_enable_o;
      prev_wr   = mem_write_o;
      prev_addr = mem_addr_o;
    end
  end

  // one CPU access held until the stall clears; returns stall count and load data
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int dly,
                        output int stalls, output logic [31:0] rv);
    @(posedge clk_i);
    #1;
    resp_delay = dly;
    MemRead_i  = rd;
    MemWrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    stalls     = 0;
    @(negedge clk_i);
    while (stall_o && stalls < 500) begin
      stalls++;
      @(negedge clk_i);
    end
    if (stall_o) chk("stall_bound", 32'(stall_o), 32'd0);
    rv = rdata_o;
    if (wr) gold[a[31:2]] = d;
    @(posedge clk_i);
    #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int st;
    int nb;
    logic [31:0] rv;

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_mem_en", 32'(mem_enable_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    MemRead_i = 1'b1;
    addr_i    = 32'h40;
    #1;
    chk("rst_req_stall", 32'(stall_o), 32'd1);
    MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // cold load: IDLE miss + MISS + 10 ALLOCATE + ALLOC_DONE = 13 stall cycles
    access(1'b1, 1'b0, 32'h40, 32'd0, 10, st, rv);
    chk("cold_stall", 32'(st), 32'd13);
    chk("cold_n_rd", 32'(n_rd), 32'd1);
    chk("cold_n_wr", 32'(n_wr), 32'd0);
    chk("cold_addr", last_rd_addr, 32'h40);
    chk("cold_rdata", rv, 32'hC0DE_0010);

    access(1'b1, 1'b0, 32'h48, 32'd0, 10, st, rv);
    chk("hit48_stall", 32'(st), 32'd0);
    chk("hit48_rdata", rv, 32'hDEAD_BEEF);

    access(1'b1, 1'b0, 32'h44, 32'd0, 10, st, rv);
    chk("hit44_stall", 32'(st), 32'd0);
    chk("hit44_rdata", rv, 32'hC0DE_0011);
    chk("hit44_n_rd", 32'(n_rd), 32'd1);

    access(1'b0, 1'b1, 32'h44, 32'h1234_5678, 4, st, rv);
    chk("st44_stall", 32'(st), 32'd0);

    // dirty eviction: miss + MISS + 4 WRITEBACK + 4 ALLOCATE + ALLOC_DONE = 11
    access(1'b1, 1'b0, 32'h444, 32'd0, 4, st, rv);
    chk("evict_stall", 32'(st), 32'd11);
    chk("evict_n_wr", 32'(n_wr), 32'd1);
    chk("evict_wb_addr", last_wb_addr, 32'h40);
    chk("evict_wb_word1", last_wb_data[63:32], 32'h1234_5678);
    chk("evict_rd_addr", last_rd_addr, 32'h440);
    chk("evict_n_rd", 32'(n_rd), 32'd2);
    chk("evict_rdata", rv, 32'hC0DE_0111);

    // line 0x440 is clean after its refill: no writeback on eviction
    access(1'b1, 1'b0, 32'h44, 32'd0, 5, st, rv);
    chk("clean1_stall", 32'(st), 32'd8);
    chk("clean1_n_wr", 32'(n_wr), 32'd1);
    chk("clean1_rdata", rv, 32'h1234_5678);

    access(1'b1, 1'b0, 32'h440, 32'd0, 5, st, rv);
    chk("clean2_stall", 32'(st), 32'd8);
    chk("clean2_n_wr", 32'(n_wr), 32'd1);
    chk("clean2_n_rd", 32'(n_rd), 32'd4);
    chk("clean2_rdata", rv, 32'hC0DE_0110);

    // read and write together behave as a store
    access(1'b1, 1'b1, 32'h448, 32'hA5A5_5A5A, 2, st, rv);
    chk("rw_stall", 32'(st), 32'd0);
    chk("rw_rdata", rv, 32'd0);
    access(1'b1, 1'b0, 32'h448, 32'd0, 2, st, rv);
    chk("rw_readback", rv, 32'hA5A5_5A5A);

    // reset in the middle of a refill
    @(posedge clk_i);
    #1;
    resp_delay = 30;
    MemRead_i  = 1'b1;
    addr_i     = 32'h860;
    nb = 0;
    @(negedge clk_i);
    while (!mem_enable_o && nb < 50) begin
      nb++;
      @(negedge clk_i);
    end
    repeat (3) @(negedge clk_i);
    #1;
    chk("abort_en_before", 32'(mem_enable_o), 32'd1);
    chk("abort_wr_before", 32'(mem_write_o), 32'd0);
    rst_i     = 1'b1;
    MemRead_i = 1'b0;
    #1;
    chk("abort_en_drop", 32'(mem_enable_o), 32'd0);
    chk("abort_stall_drop", 32'(stall_o), 32'd0);
    gold = mem_w;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("abort_n_rd", 32'(n_rd), 32'd4);

    access(1'b1, 1'b0, 32'h860, 32'd0, 3, st, rv);
    chk("reload_stall", 32'(st), 32'd6);
    chk("reload_n_rd", 32'(n_rd), 32'd5);
    chk("reload_rdata", rv, 32'hC0DE_0218);

    // the dirty 0x448 store was lost with the reset; 0x44 comes from memory
    access(1'b1, 1'b0, 32'h44, 32'd0, 2, st, rv);
    chk("post_rst_stall", 32'(st), 32'd5);
    chk("post_rst_n_wr", 32'(n_wr), 32'd1);
    chk("post_rst_rdata", rv, 32'h1234_5678);

    // no requests, random addresses, spurious acks
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      addr_i   = $urandom;
      spur_ack = (i % 3 == 0);
    end
    @(posedge clk_i);
    #1;
    spur_ack = 1'b0;
    chk("idle_n_rd", 32'(n_rd), 32'd6);
    chk("idle_n_wr", 32'(n_wr), 32'd1);

    access(1'b1, 1'b0, 32'h860, 32'd0, 3, st, rv);
    chk("after_idle_stall", 32'(st), 32'd0);
    chk("after_idle_rdata", rv, 32'hC0DE_0218);

    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
